dmd_frame_timing_gen: RTL and testbench

//  One-shot DMD video timing generator; feeds the pattern fetch stage directly upstream.
//  On frame_trig it produces exactly one frame: h_sync, v_sync, de, a first-offset-line flag and a left-offset pixel.

---
 rtl/dmd_timing_pkg.sv | 39 +++
 rtl/dmd_frame_timing_gen_if.sv | 28 ++
 rtl/dmd_wrap_counter.sv | 30 +++
 rtl/dmd_frame_timing_gen.sv | 152 +++++++++++++++
 tb/tb_dmd_frame_timing_gen.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/dmd_timing_pkg.sv
// Shared types, default timing constants and length helpers for the DMD frame timing generator.
package dmd_timing_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int unsigned OFFSET_W     = 24;

    localparam int unsigned DEF_H_SYNC   = 4;
    localparam int unsigned DEF_H_BP     = 8;
    localparam int unsigned DEF_H_ACTIVE = 82;
    localparam int unsigned DEF_H_FP     = 8;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 2;
    localparam int unsigned DEF_V_OFFSET = 1;
    localparam int unsigned DEF_V_ACTIVE = 1080;
    localparam int unsigned DEF_V_FP     = 2;
    localparam int unsigned DEF_GAP      = 16;

    function automatic int unsigned h_total(input int unsigned sync, input int unsigned bp,
                                            input int unsigned act, input int unsigned fp);
        return sync + bp + act + fp;
    endfunction

    function automatic int unsigned v_total(input int unsigned sync, input int unsigned bp,
                                            input int unsigned off, input int unsigned act,
                                            input int unsigned fp);
        return sync + bp + off + act + fp;
    endfunction

    // Counter width able to hold 0..total-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/dmd_frame_timing_gen_if.sv
// Trigger/config inputs and timing outputs of the DMD frame timing generator.
interface dmd_frame_timing_gen_if;
    import dmd_timing_pkg::*;

    logic                frame_trig;
    logic [OFFSET_W-1:0] left_offset_cfg;
    logic                frame_busy;
    logic                frame_done;
    logic                trig_missed;
    logic                h_sync_out;
    logic                v_sync_out;
    logic                de_out;
    logic                de_first_offset_line_out;
    logic [OFFSET_W-1:0] left_offset_out;

    modport master (
        output frame_trig, left_offset_cfg,
        input  frame_busy, frame_done, trig_missed, h_sync_out, v_sync_out,
               de_out, de_first_offset_line_out, left_offset_out
    );

    modport slave (
        input  frame_trig, left_offset_cfg,
        output frame_busy, frame_done, trig_missed, h_sync_out, v_sync_out,
               de_out, de_first_offset_line_out, left_offset_out
    );

endinterface

// File: rtl/dmd_wrap_counter.sv
// Counter 0..MAX with explicit wrap; wrap is high on the increment that returns it to 0.
module dmd_wrap_counter
    import dmd_timing_pkg::*;
#(
    parameter int unsigned MAX = 1,
    localparam int unsigned W  = cnt_width(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    logic [W-1:0] cnt_reg;

    assign wrap = inc && (cnt_reg == W'(MAX));
    assign cnt  = cnt_reg;

    // Clear has priority; increment wraps back to zero at MAX.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt_reg <= '0;
        end else if (inc) begin
            cnt_reg <= wrap ? '0 : cnt_reg + W'(1);
        end
    end

endmodule

// File: rtl/dmd_frame_timing_gen.sv
// One-shot DMD frame timing generator: FSM plus registered sync/de decode.
module dmd_frame_timing_gen
    import dmd_timing_pkg::*;
#(
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter int unsigned V_OFFSET   = DEF_V_OFFSET,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned GAP_CYCLES = DEF_GAP
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dmd_frame_timing_gen_if.slave bus
);

    localparam int unsigned H_TOTAL  = h_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int unsigned V_TOTAL  = v_total(V_SYNC, V_BP, V_OFFSET, V_ACTIVE, V_FP);
    localparam int unsigned HW       = cnt_width(H_TOTAL);
    localparam int unsigned VW       = cnt_width(V_TOTAL);
    localparam int unsigned GAP_MAX  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int unsigned GW       = cnt_width(GAP_MAX + 1);
    localparam int unsigned HA_START = H_SYNC + H_BP;
    localparam int unsigned HA_END   = HA_START + H_ACTIVE;
    localparam int unsigned VA_START = V_SYNC + V_BP;
    localparam int unsigned VO_END   = VA_START + V_OFFSET;
    localparam int unsigned VA_END   = VO_END + V_ACTIVE;

    generate
        if (H_ACTIVE == 0 || V_ACTIVE == 0 || H_SYNC == 0 || V_SYNC == 0) begin : g_bad_params
            $error("dmd_frame_timing_gen: H_ACTIVE, V_ACTIVE, H_SYNC and V_SYNC must be non-zero");
        end
    endgenerate

    state_t              state_reg, state_next;
    logic                start, run, frame_end, trig_missed_next;
    logic [HW-1:0]       h_cnt;
    logic [VW-1:0]       v_cnt;
    logic [GW-1:0]       gap_cnt_unused;   // only the gap wrap matters
    logic                h_wrap, v_wrap, gap_wrap;
    logic                hs_s1_reg, vs_s1_reg, de_s1_reg, first_s1_reg;
    logic                hs_reg, vs_reg, de_reg, first_reg;
    logic                busy_reg, done_reg, missed_reg;
    logic [OFFSET_W-1:0] offset_reg;

    assign run       = (state_reg == RUN);
    assign frame_end = h_wrap && v_wrap;

    dmd_wrap_counter #(.MAX(H_TOTAL - 1)) u_h_cnt (
        .clk(clk), .rst_n(rst_n), .inc(run), .clr(start), .cnt(h_cnt), .wrap(h_wrap)
    );

    dmd_wrap_counter #(.MAX(V_TOTAL - 1)) u_v_cnt (
        .clk(clk), .rst_n(rst_n), .inc(h_wrap), .clr(start), .cnt(v_cnt), .wrap(v_wrap)
    );

    dmd_wrap_counter #(.MAX(GAP_MAX)) u_gap_cnt (
        .clk(clk), .rst_n(rst_n), .inc(state_reg == GAP), .clr(start),
        .cnt(gap_cnt_unused), .wrap(gap_wrap)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state; a trigger is only accepted while idle and not busy (busy lags state by one clock).
    always_comb begin
        state_next       = state_reg;
        start            = 1'b0;
        trig_missed_next = bus.frame_trig && (state_reg != IDLE || busy_reg);
        case (state_reg)
            IDLE: begin
                if (bus.frame_trig && !busy_reg) begin
                    start      = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (frame_end) begin
                    state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_wrap) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Two-stage decode: first stage samples the counter position, second stage is the output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_s1_reg    <= 1'b0;
            vs_s1_reg    <= 1'b0;
            de_s1_reg    <= 1'b0;
            first_s1_reg <= 1'b0;
            hs_reg       <= 1'b0;
            vs_reg       <= 1'b0;
            de_reg       <= 1'b0;
            first_reg    <= 1'b0;
        end else begin
            hs_s1_reg    <= run && (32'(h_cnt) < H_SYNC);
            vs_s1_reg    <= run && (32'(v_cnt) < V_SYNC);
            de_s1_reg    <= run && (32'(h_cnt) >= HA_START) && (32'(h_cnt) < HA_END)
                                && (32'(v_cnt) >= VA_START) && (32'(v_cnt) < VA_END);
            first_s1_reg <= run && (32'(h_cnt) >= HA_START) && (32'(h_cnt) < HA_END)
                                && (32'(v_cnt) >= VA_START) && (32'(v_cnt) < VO_END);
            hs_reg       <= hs_s1_reg;
            vs_reg       <= vs_s1_reg;
            de_reg       <= de_s1_reg;
            first_reg    <= first_s1_reg;
        end
    end

    // Status pulses, busy flag and the offset latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            missed_reg <= 1'b0;
            offset_reg <= '0;
        end else begin
            busy_reg   <= (state_reg != IDLE);
            done_reg   <= run && frame_end;
            missed_reg <= trig_missed_next;
            if (start) begin
                offset_reg <= bus.left_offset_cfg;
            end
        end
    end

    assign bus.frame_busy               = busy_reg;
    assign bus.frame_done               = done_reg;
    assign bus.trig_missed              = missed_reg;
    assign bus.h_sync_out               = hs_reg;
    assign bus.v_sync_out               = vs_reg;
    assign bus.de_out                   = de_reg;
    assign bus.de_first_offset_line_out = first_reg;
    assign bus.left_offset_out          = offset_reg;

endmodule

// File: tb/tb_dmd_frame_timing_gen.sv
// Directed bench for dmd_frame_timing_gen using a small 10x7 frame geometry.
module tb_dmd_frame_timing_gen;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    dmd_frame_timing_gen_if bus0 ();
    dmd_frame_timing_gen_if bus1 ();

    dmd_frame_timing_gen #(
        .H_SYNC(2), .H_BP(2), .H_ACTIVE(4), .H_FP(2),
        .V_SYNC(1), .V_BP(1), .V_OFFSET(1), .V_ACTIVE(3), .V_FP(1), .GAP_CYCLES(3)
    ) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    dmd_frame_timing_gen #(
        .H_SYNC(2), .H_BP(2), .H_ACTIVE(4), .H_FP(2),
        .V_SYNC(1), .V_BP(1), .V_OFFSET(1), .V_ACTIVE(3), .V_FP(1), .GAP_CYCLES(0)
    ) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   m;      // clocks after the trigger sample edge
        logic busy;
        logic vs;
        logic hs;
        logic de;
        logic first;
        logic done;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One frame on dut0 starting with a trigger; optional stray triggers at k+5 and on the done cycle.
    task automatic run_frame(input bit stray, input int frame_id);
        int   de_n, first_n, hs_n, vs_n, burst_n, missed_n;
        logic de_prev;
        de_n = 0; first_n = 0; hs_n = 0; vs_n = 0; burst_n = 0; missed_n = 0;
        de_prev = 1'b0;
        bus0.left_offset_cfg = 24'hA5A5A5;
        bus0.frame_trig = 1'b1;
        @(posedge clk); #1;
        bus0.frame_trig = 1'b0;
        for (int m = 0; m <= 74; m++) begin
            if (m > 0) begin
                @(posedge clk); #1;
            end
            if (bus0.de_out) de_n++;
            if (bus0.de_first_offset_line_out) first_n++;
            if (bus0.h_sync_out) hs_n++;
            if (bus0.v_sync_out) vs_n++;
            if (bus0.trig_missed) missed_n++;
            if (bus0.de_out && !de_prev) burst_n++;
            de_prev = bus0.de_out;
            for (int i = 0; i < 17; i++) begin
                if (tbl[i].m == m) begin
                    check($sformatf("f%0d busy@%0d", frame_id, m), 32'(bus0.frame_busy), 32'(tbl[i].busy));
                    check($sformatf("f%0d vsync@%0d", frame_id, m), 32'(bus0.v_sync_out), 32'(tbl[i].vs));
                    check($sformatf("f%0d hsync@%0d", frame_id, m), 32'(bus0.h_sync_out), 32'(tbl[i].hs));
                    check($sformatf("f%0d de@%0d", frame_id, m), 32'(bus0.de_out), 32'(tbl[i].de));
                    check($sformatf("f%0d first@%0d", frame_id, m),
                          32'(bus0.de_first_offset_line_out), 32'(tbl[i].first));
                    check($sformatf("f%0d done@%0d", frame_id, m), 32'(bus0.frame_done), 32'(tbl[i].done));
                end
            end
            if (m == 20) bus0.left_offset_cfg = 24'h123456;
            if (m == 40) check($sformatf("f%0d left_offset", frame_id), 32'(bus0.left_offset_out), 32'hA5A5A5);
            bus0.frame_trig = stray && (m == 4 || m == 70);
        end
        bus0.frame_trig = 1'b0;
        check($sformatf("f%0d de_count", frame_id), 32'(de_n), 32'd16);
        check($sformatf("f%0d first_count", frame_id), 32'(first_n), 32'd4);
        check($sformatf("f%0d de_bursts", frame_id), 32'(burst_n), 32'd4);
        check($sformatf("f%0d hsync_count", frame_id), 32'(hs_n), 32'd14);
        check($sformatf("f%0d vsync_count", frame_id), 32'(vs_n), 32'd10);
        check($sformatf("f%0d trig_missed_count", frame_id), 32'(missed_n), stray ? 32'd2 : 32'd0);
        $display("frame %0d: de=%0d first=%0d bursts=%0d hs=%0d vs=%0d missed=%0d",
                 frame_id, de_n, first_n, burst_n, hs_n, vs_n, missed_n);
    endtask

    initial begin
        int   act_n;
        pass_cnt  = 0;
        total_cnt = 0;
        //             m  busy vs hs de fst done
        tbl[0]  = '{  0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{  1, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{  2, 1, 1, 1, 0, 0, 0};
        tbl[3]  = '{  3, 1, 1, 1, 0, 0, 0};
        tbl[4]  = '{  4, 1, 1, 0, 0, 0, 0};
        tbl[5]  = '{ 11, 1, 1, 0, 0, 0, 0};
        tbl[6]  = '{ 12, 1, 0, 1, 0, 0, 0};
        tbl[7]  = '{ 26, 1, 0, 0, 1, 1, 0};
        tbl[8]  = '{ 29, 1, 0, 0, 1, 1, 0};
        tbl[9]  = '{ 30, 1, 0, 0, 0, 0, 0};
        tbl[10] = '{ 36, 1, 0, 0, 1, 0, 0};
        tbl[11] = '{ 59, 1, 0, 0, 1, 0, 0};
        tbl[12] = '{ 66, 1, 0, 0, 0, 0, 0};
        tbl[13] = '{ 70, 1, 0, 0, 0, 0, 1};
        tbl[14] = '{ 71, 1, 0, 0, 0, 0, 0};
        tbl[15] = '{ 73, 1, 0, 0, 0, 0, 0};
        tbl[16] = '{ 74, 0, 0, 0, 0, 0, 0};

        rst_n = 1'b0;
        bus0.frame_trig = 1'b0;
        bus0.left_offset_cfg = 24'h0;
        bus1.frame_trig = 1'b0;
        bus1.left_offset_cfg = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(bus0.frame_busy), 32'd0);
        check("reset vsync", 32'(bus0.v_sync_out), 32'd0);
        check("reset hsync", 32'(bus0.h_sync_out), 32'd0);
        check("reset de", 32'(bus0.de_out), 32'd0);
        check("reset done", 32'(bus0.frame_done), 32'd0);
        check("reset missed", 32'(bus0.trig_missed), 32'd0);
        check("reset left_offset", 32'(bus0.left_offset_out), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle busy", 32'(bus0.frame_busy), 32'd0);

        // Clean frame, then a second one triggered one clock after busy drops, with stray triggers.
        run_frame(1'b0, 1);
        run_frame(1'b1, 2);

        // The trigger on the done cycle must not have started another frame.
        act_n = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus0.frame_busy || bus0.v_sync_out || bus0.h_sync_out) act_n++;
        end
        check("no frame after missed trig", 32'(act_n), 32'd0);

        // Reset for one clock on line 3 of a frame.
        bus0.left_offset_cfg = 24'h5A5A5A;
        bus0.frame_trig = 1'b1;
        @(posedge clk); #1;
        bus0.frame_trig = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        check("pre-reset busy", 32'(bus0.frame_busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid reset busy", 32'(bus0.frame_busy), 32'd0);
        check("mid reset vsync", 32'(bus0.v_sync_out), 32'd0);
        check("mid reset hsync", 32'(bus0.h_sync_out), 32'd0);
        check("mid reset de", 32'(bus0.de_out), 32'd0);
        check("mid reset first", 32'(bus0.de_first_offset_line_out), 32'd0);
        check("mid reset left_offset", 32'(bus0.left_offset_out), 32'd0);
        act_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus0.frame_busy || bus0.v_sync_out || bus0.h_sync_out || bus0.de_out
                || bus0.frame_done) act_n++;
        end
        check("quiet after reset", 32'(act_n), 32'd0);
        $display("mid-frame reset: activity cycles=%0d", act_n);

        // Zero-gap instance: busy drops one clock after done, back-to-back frames.
        for (int f = 0; f < 2; f++) begin
            bus1.frame_trig = 1'b1;
            @(posedge clk); #1;
            bus1.frame_trig = 1'b0;
            for (int m = 0; m <= 71; m++) begin
                if (m > 0) begin
                    @(posedge clk); #1;
                end
                if (m == 1)  check($sformatf("g0 f%0d busy@1", f), 32'(bus1.frame_busy), 32'd1);
                if (m == 2)  check($sformatf("g0 f%0d vsync@2", f), 32'(bus1.v_sync_out), 32'd1);
                if (m == 69) check($sformatf("g0 f%0d done@69", f), 32'(bus1.frame_done), 32'd0);
                if (m == 70) check($sformatf("g0 f%0d done@70", f), 32'(bus1.frame_done), 32'd1);
                if (m == 70) check($sformatf("g0 f%0d busy@70", f), 32'(bus1.frame_busy), 32'd1);
                if (m == 71) check($sformatf("g0 f%0d busy@71", f), 32'(bus1.frame_busy), 32'd0);
            end
            $display("zero-gap frame %0d complete", f);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
